chan_burst_injector: RTL

- Channel model between the rate-1/2 convolutional encoder and the Viterbi decoder.
- Registers each 2-bit encoded symbol and XORs in pseudo-random burst errors: once triggered, BURST_LEN consecutive symbols are corrupted, followed by a clean guard interval.
- Keeps running symbol and bad-bit counts so benches can correlate decoder output errors with channel bit error rate.

---
 rtl/chan_pkg.sv | 13 +
 rtl/chan_burst_injector_lfsr32.sv | 19 +
 rtl/chan_burst_injector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/chan_pkg.sv
// Shared types and constants for the burst-error channel model.
package chan_pkg;

  typedef enum logic [1:0] {CLEAN, BURST, GUARD} chan_state_e;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/chan_burst_injector_lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1); shifts once per advance pulse.
import chan_pkg::*;

module lfsr32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= seed;
    else if (advance)
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/chan_burst_injector.sv
// Channel model: registers 2-bit symbols and XORs in LFSR-driven burst errors.
// Define CHAN_STATS_EN to build the saturating symbol / bad-bit counters.
import chan_pkg::*;

module chan_burst_injector #(
  parameter int          N         = 3,
  parameter int          BURST_LEN = 2,
  parameter int          GUARD_LEN = 4,
  parameter logic [31:0] SEED      = DEFAULT_SEED,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inj_en,
  input  logic             valid_i,
  input  logic [1:0]       sym_i,
  output logic             valid_o,
  output logic [1:0]       sym_o,
  output logic [1:0]       err_mask_o,
  output logic             in_burst_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] bad_bit_ct_o
);

  localparam logic [3:0] BURST_REM0 = 4'(BURST_LEN - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_LEN - 1);

  logic [31:0] lfsr;
  chan_state_e state, state_n;
  logic [3:0]  burst_rem, rem_n;
  logic [7:0]  guard_cnt, gcnt_n;
  logic [1:0]  mask, burst_mask;
  logic        trigger;

  lfsr32 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .advance(valid_i),
    .seed   (SEED),
    .state  (lfsr)
  );

  // All decisions below look at the LFSR before this symbol advances it.
  assign trigger    = &lfsr[N-1:0];
  assign burst_mask = (lfsr[29:28] == 2'b00) ? 2'b01 : lfsr[29:28];
  assign in_burst_o = (state == BURST);

  always_comb begin
    mask    = 2'b00;
    state_n = state;
    rem_n   = burst_rem;
    gcnt_n  = guard_cnt;
    if (!inj_en) begin
      state_n = CLEAN;
      rem_n   = '0;
      gcnt_n  = '0;
    end else begin
      case (state)
        CLEAN: if (trigger) begin
          mask = burst_mask;
          if (BURST_LEN > 1) begin
            state_n = BURST;
            rem_n   = BURST_REM0;
          end else if (GUARD_LEN > 0) begin
            state_n = GUARD;
            gcnt_n  = '0;
          end
        end
        BURST: begin
          mask = burst_mask;
          if (burst_rem == 4'd1) begin
            rem_n   = '0;
            gcnt_n  = '0;
            state_n = (GUARD_LEN > 0) ? GUARD : CLEAN;
          end else begin
            rem_n = burst_rem - 4'd1;
          end
        end
        GUARD: begin
          // Guard always completes before any new trigger is looked at.
          if (guard_cnt == GUARD_LAST) begin
            state_n = CLEAN;
            gcnt_n  = '0;
          end else begin
            gcnt_n = guard_cnt + 8'd1;
          end
        end
        default: state_n = CLEAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAN;
      burst_rem  <= '0;
      guard_cnt  <= '0;
      valid_o    <= 1'b0;
      sym_o      <= '0;
      err_mask_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        state      <= state_n;
        burst_rem  <= rem_n;
        guard_cnt  <= gcnt_n;
        sym_o      <= sym_i ^ mask;
        err_mask_o <= mask;
      end
    end
  end

`ifdef CHAN_STATS_EN
  logic [CNT_W-1:0] sym_ct, bad_ct;
  logic [CNT_W:0]   bad_sum;

  // One spare bit catches the overflow so the count can clamp instead of wrap.
  assign bad_sum = {1'b0, bad_ct} + (CNT_W+1)'(popcount2(mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct <= '0;
      bad_ct <= '0;
    end else if (valid_i) begin
      if (sym_ct != '1) sym_ct <= sym_ct + 1'b1;
      bad_ct <= bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
    end
  end

  assign sym_ct_o     = sym_ct;
  assign bad_bit_ct_o = bad_ct;
`else
  assign sym_ct_o     = '0;
  assign bad_bit_ct_o = '0;
`endif

endmodule
